// File: rtl/spart_driver_if.sv
// Processor-side SPART bus: strobe, direction and address from the initiator, status flags back from the SPART.
// The bidirectional databus is not part of this interface; it stays a plain inout port on the modules.
interface spart_driver_if;
   logic       iocs;
   logic       iorw;
   logic [1:0] ioaddr;
   logic       rda;
   logic       tbr;

   modport master (
      output iocs,
      output iorw,
      output ioaddr,
      input  rda,
      input  tbr
   );

   modport slave (
      input  iocs,
      input  iorw,
      input  ioaddr,
      output rda,
      output tbr
   );
endinterface

// File: rtl/spart_driver.sv
// spart_driver: programs the SPART baud divisor from br_cfg, then echoes each received byte through a FIFO_DEPTH-entry FIFO.
// Optional macro SPART_DRV_CASE_FLIP_EN inverts bit 5 of ASCII letters on the transmit path only.
module spart_driver #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [1:0]                    br_cfg,
   spart_driver_if.master                bus,
   inout  wire  [7:0]                    databus,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [7:0]                    last_rx
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);

   if (CLK_HZ <= 0 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
      $error("spart_driver: CLK_HZ must be positive and FIFO_DEPTH a power of two");
   end

   typedef enum logic [2:0] {
      CFG_LO,
      CFG_HI,
      IDLE,
      RD_HOLD,
      WR_HOLD
   } state_t;

   state_t        state_q, state_d;
   logic          iocs_q, iocs_d;
   logic          iorw_q, iorw_d;
   logic [1:0]    ioaddr_q, ioaddr_d;
   logic [7:0]    dat_q, dat_d;
   logic [1:0]    br_q, br_d;
   logic [1:0]    cfg_used_q, cfg_used_d;
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [7:0]    mem_d [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   logic [7:0]    last_rx_q, last_rx_d;

   logic          push;
   logic          fifo_full;
   logic          fifo_empty;
   logic [15:0]   div_new;
   logic [15:0]   div_cur;

   // Divisors for 16x oversampling at 50 MHz; fixed constants, not derived from CLK_HZ.
   function automatic logic [15:0] divisor(input logic [1:0] sel);
      logic [15:0] d;
      case (sel)
         2'b00:   d = 16'd650;
         2'b01:   d = 16'd325;
         2'b10:   d = 16'd162;
         default: d = 16'd80;
      endcase
      return d;
   endfunction

   function automatic logic [7:0] tx_xform(input logic [7:0] b);
      logic [7:0] r;
      r = b;
`ifdef SPART_DRV_CASE_FLIP_EN
      if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A)) begin
         r = b ^ 8'h20;
      end
`endif
      return r;
   endfunction

   assign div_new    = divisor(br_q);
   assign div_cur    = divisor(cfg_used_q);
   assign fifo_full  = (count_q == FULL_CNT);
   assign fifo_empty = (count_q == '0);
   // A read strobe is the only transaction with iorw=1, so it marks the cycle whose end captures databus.
   assign push       = iocs_q && iorw_q && (ioaddr_q == 2'b00);

   always_comb begin
      state_d    = state_q;
      iocs_d     = 1'b0;
      iorw_d     = 1'b1;
      ioaddr_d   = 2'b00;
      dat_d      = dat_q;
      br_d       = br_cfg;
      cfg_used_d = cfg_used_q;
      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      last_rx_d  = last_rx_q;

      if (push) begin
         mem_d[wr_ptr_q] = databus;
         wr_ptr_d        = wr_ptr_q + 1'b1;
         count_d         = count_q + 1'b1;
         last_rx_d       = databus;
      end

      case (state_q)
         CFG_LO: begin
            iocs_d     = 1'b1;
            iorw_d     = 1'b0;
            ioaddr_d   = 2'b10;
            dat_d      = div_new[7:0];
            cfg_used_d = br_q;
            state_d    = CFG_HI;
         end
         CFG_HI: begin
            iocs_d   = 1'b1;
            iorw_d   = 1'b0;
            ioaddr_d = 2'b11;
            dat_d    = div_cur[15:8];
            state_d  = IDLE;
         end
         IDLE: begin
            if (br_q != cfg_used_q) begin
               state_d = CFG_LO;
            end else if (bus.rda && !fifo_full) begin
               iocs_d  = 1'b1;
               iorw_d  = 1'b1;
               state_d = RD_HOLD;
            end else if (bus.tbr && !fifo_empty) begin
               // Pop happens here, as the write is launched; push only occurs in RD_HOLD, so they never collide.
               iocs_d   = 1'b1;
               iorw_d   = 1'b0;
               dat_d    = tx_xform(mem_q[rd_ptr_q]);
               rd_ptr_d = rd_ptr_q + 1'b1;
               count_d  = count_q - 1'b1;
               state_d  = WR_HOLD;
            end
         end
         RD_HOLD, WR_HOLD: begin
            state_d = IDLE;
         end
         default: begin
            state_d = CFG_LO;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      br_q  <= br_d;
      mem_q <= mem_d;
      if (rst) begin
         state_q    <= CFG_LO;
         iocs_q     <= 1'b0;
         iorw_q     <= 1'b1;
         ioaddr_q   <= 2'b00;
         dat_q      <= 8'h00;
         cfg_used_q <= 2'b00;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         last_rx_q  <= 8'h00;
      end else begin
         state_q    <= state_d;
         iocs_q     <= iocs_d;
         iorw_q     <= iorw_d;
         ioaddr_q   <= ioaddr_d;
         dat_q      <= dat_d;
         cfg_used_q <= cfg_used_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         last_rx_q  <= last_rx_d;
      end
   end

   assign bus.iocs   = iocs_q;
   assign bus.iorw   = iorw_q;
   assign bus.ioaddr = ioaddr_q;
   assign databus    = (iocs_q && !iorw_q) ? dat_q : 8'hzz;
   assign fifo_count = count_q;
   assign last_rx    = last_rx_q;

endmodule

// File: tb/tb_spart_driver.sv
// Bench for spart_driver: behavioural SPART (byte queue + tbr flag) and a reference echo queue checked every cycle.
// Table of divisor vectors, hand sequences for the corner cases, then a randomized traffic phase.
module tb_spart_driver;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] br_cfg = 2'b01;
   wire  [7:0] databus;
   logic [2:0] fifo_count;
   logic [7:0] last_rx;

   spart_driver_if bus ();

   spart_driver #(.CLK_HZ(50_000_000), .FIFO_DEPTH(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .br_cfg     (br_cfg),
      .bus        (bus),
      .databus    (databus),
      .fifo_count (fifo_count),
      .last_rx    (last_rx)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // SPART side: bytes waiting to be read, transmit-ready flag, data driven during reads.
   logic [7:0] rx_q[$];
   int         rx_cnt = 0;
   logic       tbr_en = 1'b0;
   logic       probe  = 1'b0;
   logic [7:0] tb_dat = 8'h00;

   assign bus.rda = (rx_cnt != 0);
   assign bus.tbr = tbr_en;
   assign databus = probe ? 8'h5A : ((bus.iocs && bus.iorw) ? tb_dat : 8'hzz);

   typedef struct {
      int         cyc;
      logic [1:0] addr;
      logic [7:0] dat;
      logic       rd;
   } ev_t;

   typedef struct {
      logic [1:0] br;
      logic [7:0] lo;
      logic [7:0] hi;
   } cfg_vec_t;

   ev_t        cfg_log[$];
   ev_t        ev_log[$];
   logic [7:0] m_fifo[$];
   logic [7:0] m_last = 8'h00;
   logic       prev_s0 = 1'b0;
   logic       s0;
   logic [7:0] mb;
   cfg_vec_t   tbl[4];
   int         rel;
   int         nsent;
   int         k;
   logic [7:0] wq[$];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [7:0] xf(input logic [7:0] b);
      logic [7:0] r;
      r = b;
`ifdef SPART_DRV_CASE_FLIP_EN
      if ((b >= "A" && b <= "Z") || (b >= "a" && b <= "z")) r = b ^ 8'h20;
`endif
      return r;
   endfunction

   task automatic send(input logic [7:0] b);
      rx_q.push_back(b);
      rx_cnt++;
   endtask

   function automatic int n_rd();
      int n = 0;
      foreach (ev_log[i]) if (ev_log[i].rd) n++;
      return n;
   endfunction

   task automatic wait_ev(input int n, input int budget, input string name);
      int w = 0;
      while (ev_log.size() < n && w < budget) begin
         @(negedge clk);
         w++;
      end
      chk(name, int'(ev_log.size() >= n), 1);
   endtask

   task automatic collect_writes();
      wq.delete();
      foreach (ev_log[i]) if (!ev_log[i].rd) wq.push_back(ev_log[i].dat);
   endtask

   always @(posedge clk) cyc++;

   // Reference model: the echo stream is exactly the read stream in order, bounded by 4 in flight.
   always @(negedge clk) begin
      if (rst) begin
         m_fifo.delete();
         m_last  = 8'h00;
         prev_s0 = 1'b0;
      end else begin
         s0 = bus.iocs && (bus.ioaddr == 2'b00);
         if (bus.iocs && !bus.iorw && bus.ioaddr[1])
            cfg_log.push_back('{cyc, bus.ioaddr, databus, 1'b0});
         if (s0) chk("no_back_to_back_strobe", int'(prev_s0), 0);
         if (s0 && !bus.iorw) begin
            chk("write_needs_queued_byte", int'(m_fifo.size() != 0), 1);
            if (m_fifo.size() != 0) begin
               mb = m_fifo.pop_front();
               chk("echo_data", int'(databus), int'(xf(mb)));
            end
            ev_log.push_back('{cyc, 2'b00, databus, 1'b0});
         end
         chk("fifo_count", int'(fifo_count), m_fifo.size());
         chk("last_rx", int'(last_rx), int'(m_last));
         if (s0 && bus.iorw) begin
            chk("read_only_when_not_full", int'(m_fifo.size() < 4), 1);
            chk("read_only_with_rda", int'(rx_q.size() != 0), 1);
            if (rx_q.size() != 0) begin
               mb = rx_q.pop_front();
               rx_cnt--;
               tb_dat = mb;
               m_fifo.push_back(mb);
               m_last = mb;
               ev_log.push_back('{cyc, 2'b00, mb, 1'b1});
            end
         end
         prev_s0 = s0;
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{2'b00, 8'h8A, 8'h02};
      tbl[1] = '{2'b10, 8'hA2, 8'h00};
      tbl[2] = '{2'b11, 8'h50, 8'h00};
      tbl[3] = '{2'b01, 8'h45, 8'h01};

      // Divisor programming after reset for every baud select; last entry leaves 9600 active.
      for (int i = 0; i < 4; i++) begin
         rst    = 1'b1;
         br_cfg = tbl[i].br;
         repeat (3) @(negedge clk);
         if (i == 0) begin
            chk("rst_iocs", int'(bus.iocs), 0);
            chk("rst_iorw", int'(bus.iorw), 1);
            chk("rst_ioaddr", int'(bus.ioaddr), 0);
            chk("rst_fifo_count", int'(fifo_count), 0);
            chk("rst_last_rx", int'(last_rx), 0);
            probe = 1'b1;
            #1;
            chk("rst_databus_released", int'(databus), 8'h5A);
            probe = 1'b0;
         end
         cfg_log.delete();
         ev_log.delete();
         rel = cyc;
         rst = 1'b0;
         repeat (6) @(negedge clk);
         chk("cfg_write_count", cfg_log.size(), 2);
         if (cfg_log.size() == 2) begin
            chk("cfg_lo_addr", int'(cfg_log[0].addr), 2);
            chk("cfg_lo_data", int'(cfg_log[0].dat), int'(tbl[i].lo));
            chk("cfg_lo_cycle", cfg_log[0].cyc, rel + 1);
            chk("cfg_hi_addr", int'(cfg_log[1].addr), 3);
            chk("cfg_hi_data", int'(cfg_log[1].dat), int'(tbl[i].hi));
            chk("cfg_hi_cycle", cfg_log[1].cyc, rel + 2);
         end
         chk("idle_quiet", ev_log.size(), 0);
      end

      // Single echo with tbr already high: read at N, write at N+2.
      ev_log.delete();
      tbr_en = 1'b1;
      send(8'h61);
      wait_ev(2, 20, "echo_wait");
      if (ev_log.size() >= 2) begin
         chk("echo_first_is_read", int'(ev_log[0].rd), 1);
         chk("echo_second_is_write", int'(ev_log[1].rd), 0);
         chk("echo_write_data", int'(ev_log[1].dat), int'(xf(8'h61)));
         chk("echo_latency", ev_log[1].cyc - ev_log[0].cyc, 2);
      end
      repeat (2) @(negedge clk);
      chk("echo_count_drained", int'(fifo_count), 0);
      chk("echo_last_rx", int'(last_rx), 8'h61);

      // Six bytes with tbr low: FIFO fills at 4, rest stays in the SPART.
      ev_log.delete();
      tbr_en = 1'b0;
      for (int i = 0; i < 6; i++) send(8'h10 + 8'(i));
      repeat (30) @(negedge clk);
      chk("full_reads", n_rd(), 4);
      chk("full_count", int'(fifo_count), 4);
      chk("full_rda_high", int'(bus.rda), 1);
      chk("full_left_in_spart", rx_cnt, 2);
      tbr_en = 1'b1;
      wait_ev(12, 60, "full_drain_wait");
      collect_writes();
      chk("full_write_total", wq.size(), 6);
      for (int i = 0; i < 6 && i < wq.size(); i++)
         chk("full_write_order", int'(wq[i]), int'(xf(8'h10 + 8'(i))));
      repeat (3) @(negedge clk);
      chk("full_count_end", int'(fifo_count), 0);

      // rda and tbr together with 2 bytes queued: read goes first.
      tbr_en = 1'b0;
      send(8'hA0);
      send(8'hA1);
      repeat (12) @(negedge clk);
      chk("prio_queued", int'(fifo_count), 2);
      ev_log.delete();
      send(8'hA2);
      tbr_en = 1'b1;
      wait_ev(4, 30, "prio_wait");
      if (ev_log.size() >= 4) begin
         chk("prio_read_first", int'(ev_log[0].rd), 1);
         for (int i = 1; i < 4; i++) begin
            chk("prio_write_order", int'(ev_log[i].dat), int'(xf(8'hA0 + 8'(i - 1))));
            chk("prio_spacing", int'(ev_log[i].cyc - ev_log[i-1].cyc >= 2), 1);
         end
      end

      // Baud change while idle, with bytes still queued.
      br_cfg = 2'b00;
      repeat (8) @(negedge clk);
      tbr_en = 1'b0;
      send(8'h5B);
      send(8'h7A);
      repeat (12) @(negedge clk);
      cfg_log.delete();
      ev_log.delete();
      br_cfg = 2'b11;
      repeat (8) @(negedge clk);
      chk("rebaud_writes", cfg_log.size(), 2);
      if (cfg_log.size() == 2) begin
         chk("rebaud_lo_addr", int'(cfg_log[0].addr), 2);
         chk("rebaud_lo_data", int'(cfg_log[0].dat), 8'h50);
         chk("rebaud_hi_addr", int'(cfg_log[1].addr), 3);
         chk("rebaud_hi_data", int'(cfg_log[1].dat), 8'h00);
      end
      chk("rebaud_fifo_kept", int'(fifo_count), 2);
      tbr_en = 1'b1;
      wait_ev(2, 30, "rebaud_echo_wait");
      collect_writes();
      chk("rebaud_echo_count", wq.size(), 2);
      if (wq.size() == 2) begin
         chk("rebaud_echo_0", int'(wq[0]), int'(xf(8'h5B)));
         chk("rebaud_echo_1", int'(wq[1]), int'(xf(8'h7A)));
      end

      // Reset during a write with 3 bytes queued.
      tbr_en = 1'b0;
      send(8'hC0);
      send(8'hC1);
      send(8'hC2);
      repeat (15) @(negedge clk);
      chk("rstw_queued", int'(fifo_count), 3);
      tbr_en = 1'b1;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!(bus.iocs && !bus.iorw && bus.ioaddr == 2'b00) && k < 20);
      chk("rstw_write_seen", int'(k < 20), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("rstw_iocs", int'(bus.iocs), 0);
      chk("rstw_fifo_count", int'(fifo_count), 0);
      probe = 1'b1;
      #1;
      chk("rstw_databus_released", int'(databus), 8'h5A);
      probe = 1'b0;
      cfg_log.delete();
      rel = cyc;
      rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("rstw_cfg_writes", cfg_log.size(), 2);
      if (cfg_log.size() == 2) begin
         chk("rstw_cfg_lo", int'(cfg_log[0].dat), 8'h50);
         chk("rstw_cfg_lo_cycle", cfg_log[0].cyc, rel + 1);
         chk("rstw_cfg_hi", int'(cfg_log[1].dat), 8'h00);
         chk("rstw_cfg_hi_cycle", cfg_log[1].cyc, rel + 2);
      end

      // Randomized traffic against the reference queue.
      ev_log.delete();
      nsent = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if ($urandom_range(0, 3) == 0 && rx_cnt < 3) begin
            send(8'($urandom));
            nsent++;
         end
         tbr_en = ($urandom_range(0, 2) != 0);
      end
      tbr_en = 1'b1;
      repeat (60) @(negedge clk);
      collect_writes();
      chk("rand_all_read", n_rd(), nsent);
      chk("rand_all_echoed", wq.size(), nsent);
      chk("rand_spart_empty", rx_cnt, 0);
      chk("rand_fifo_empty", int'(fifo_count), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
